// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and helpers for the data-memory arbiter.
//   arb_state_t : transaction sequencer states (IDLE -> ACCESS -> RESP)
//   WORD_IDX_W  : word-index width of the default 512-word memory
//   addr_legal  : true when a byte address is word aligned and inside memory
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   localparam int unsigned MEM_WORDS_DEFAULT = 32'd512;
   localparam int unsigned WORD_IDX_W        = $clog2(MEM_WORDS_DEFAULT);

   // Word index is addr[31:2]; anything misaligned or past the last word is rejected.
   function automatic logic addr_legal(input logic [31:0] addr, input int unsigned words);
      logic [31:0] word_idx;
      word_idx = {2'b00, addr[31:2]};
      return (addr[1:0] == 2'b00) && (word_idx < words);
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles both requester channels and the memory port of the arbiter.
//   req/we/addr0/addr1/wdata0/wdata1 : requester -> arbiter
//   ack/err/rdata                    : arbiter -> requester
//   mem_address/mem_write_data/mem_read/mem_write : arbiter -> memory
//   mem_read_data                    : memory -> arbiter (combinational read)
// slave modport is the arbiter's view, master is the environment's view.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
   parameter int DATA_W = 32
) ();

   logic [1:0]        req;
   logic [1:0]        we;
   logic [DATA_W-1:0] addr0;
   logic [DATA_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic [1:0]        ack;
   logic              err;
   logic [DATA_W-1:0] rdata;
   logic [DATA_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] mem_read_data;

   modport slave (
      input  req, we, addr0, addr1, wdata0, wdata1, mem_read_data,
      output ack, err, rdata, mem_address, mem_write_data, mem_read, mem_write
   );

   modport master (
      output req, we, addr0, addr1, wdata0, wdata1, mem_read_data,
      input  ack, err, rdata, mem_address, mem_write_data, mem_read, mem_write
   );

endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin pick.
//   req[1:0] : pending requests
//   last     : index of the most recently granted requester
//   gnt_idx  : index of the winner (valid when any = 1)
//   any      : at least one request pending
// -----------------------------------------------------------------------------
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt_idx,
   output logic       any
);

   // Sole requester wins; on a tie the one not granted last time wins.
   always_comb begin
      any     = |req;
      gnt_idx = 1'b0;
      case (req)
         2'b01:   gnt_idx = 1'b0;
         2'b10:   gnt_idx = 1'b1;
         2'b11:   gnt_idx = ~last;
         default: gnt_idx = 1'b0;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-cycle data-memory port between requester 0 (CPU) and
// requester 1 (DMA). Each grant runs IDLE -> ACCESS -> RESP; the memory is
// strobed for exactly the ACCESS cycle and ack[owner] pulses in RESP.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dmem_arbiter_if.slave (requester channels + memory port)
// All outputs come straight from flops; none depend combinationally on req.
// -----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int          DATA_W    = 32,
   parameter int unsigned MEM_WORDS = 512
) (
   input  logic           clk,
   input  logic           rst_n,
   dmem_arbiter_if.slave  bus
);

   arb_state_t        state_q, state_d;
   logic              last_q, last_d;
   logic              owner_q, owner_d;
   logic              lat_we_q, lat_we_d;
   logic [DATA_W-1:0] lat_addr_q, lat_addr_d;
   logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
   logic [1:0]        ack_q, ack_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;

   logic              gnt_idx_s;
   logic              any_s;
   logic [DATA_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_wdata_s;
   logic              sel_we_s;
   logic              sel_legal_s;
   logic              lat_legal_s;

   rr_arbiter2 u_rr (
      .req     (bus.req),
      .last    (last_q),
      .gnt_idx (gnt_idx_s),
      .any     (any_s)
   );

   // Mux the winning requester's channel for latching.
   always_comb begin
      if (gnt_idx_s) begin
         sel_addr_s  = bus.addr1;
         sel_wdata_s = bus.wdata1;
         sel_we_s    = bus.we[1];
      end else begin
         sel_addr_s  = bus.addr0;
         sel_wdata_s = bus.wdata0;
         sel_we_s    = bus.we[0];
      end
      sel_legal_s = addr_legal(32'(sel_addr_s), MEM_WORDS);
      lat_legal_s = addr_legal(32'(lat_addr_q), MEM_WORDS);
   end

   // Next-state and next-output logic. Strobes are computed one cycle early
   // so they are flop outputs during ACCESS; ack/err/rdata likewise for RESP.
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      lat_we_d    = lat_we_q;
      lat_addr_d  = lat_addr_q;
      lat_wdata_d = lat_wdata_q;
      ack_d       = 2'b00;
      err_d       = 1'b0;
      rdata_d     = '0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_s) begin
               state_d     = ACCESS;
               last_d      = gnt_idx_s;
               owner_d     = gnt_idx_s;
               lat_we_d    = sel_we_s;
               lat_addr_d  = sel_addr_s;
               lat_wdata_d = sel_wdata_s;
               mem_write_d = sel_legal_s & sel_we_s;
               mem_read_d  = sel_legal_s & ~sel_we_s;
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            state_d = RESP;
            ack_d   = owner_q ? 2'b10 : 2'b01;
            err_d   = ~lat_legal_s;
            // Only a legal load carries data back; stores and errors return 0.
            if (mem_read_q) begin
               rdata_d = bus.mem_read_data;
            end else begin
               rdata_d = '0;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         owner_q     <= 1'b0;
         lat_we_q    <= 1'b0;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
         ack_q       <= 2'b00;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         lat_we_q    <= lat_we_d;
         lat_addr_q  <= lat_addr_d;
         lat_wdata_q <= lat_wdata_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
      end
   end

   assign bus.ack            = ack_q;
   assign bus.err            = err_q;
   assign bus.rdata          = rdata_q;
   assign bus.mem_address    = lat_addr_q;
   assign bus.mem_write_data = lat_wdata_q;
   assign bus.mem_read       = mem_read_q;
   // Gate with rst_n so a write caught by reset can never reach the memory edge.
   assign bus.mem_write      = mem_write_q & rst_n;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a behavioural 512-word memory.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   dmem_arbiter_if #(.DATA_W(32)) bus ();

   dmem_arbiter #(.DATA_W(32), .MEM_WORDS(512)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Memory model: combinational read, write on rising edge, bench preload port.
   logic [31:0]           mem [0:MEM_WORDS_DEFAULT-1];
   logic                  pre_en;
   logic [WORD_IDX_W-1:0] pre_idx;
   logic [31:0]           pre_val;

   assign bus.mem_read_data = mem[bus.mem_address[WORD_IDX_W+1:2]];

   always @(posedge clk) begin
      if (pre_en) begin
         mem[pre_idx] <= pre_val;
      end else if (bus.mem_write) begin
         mem[bus.mem_address[WORD_IDX_W+1:2]] <= bus.mem_write_data;
      end
   end

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] val);
      pre_en  = 1'b1;
      pre_idx = idx[WORD_IDX_W-1:0];
      pre_val = val;
      tick();
      pre_en  = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ack"},   32'(bus.ack), 32'd0);
      check({tag, "_err"},   32'(bus.err), 32'd0);
      check({tag, "_rdata"}, bus.rdata, 32'd0);
      check({tag, "_mrd"},   32'(bus.mem_read), 32'd0);
      check({tag, "_mwr"},   32'(bus.mem_write), 32'd0);
      check({tag, "_maddr"}, bus.mem_address, 32'd0);
      check({tag, "_mwd"},   bus.mem_write_data, 32'd0);
   endtask

   // One full transaction from requester r with the expected response.
   task automatic do_access(input string tag, input int r, input logic w,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic exp_err, input logic [31:0] exp_rd);
      logic [1:0] exp_ack;
      exp_ack = (r == 1) ? 2'b10 : 2'b01;
      if (r == 1) begin
         bus.addr1  = a;
         bus.wdata1 = d;
         bus.we     = {w, 1'b0};
         bus.req    = 2'b10;
      end else begin
         bus.addr0  = a;
         bus.wdata0 = d;
         bus.we     = {1'b0, w};
         bus.req    = 2'b01;
      end
      tick();  // ACCESS cycle
      check({tag, "_acc_mrd"},   32'(bus.mem_read),  32'(!exp_err && !w));
      check({tag, "_acc_mwr"},   32'(bus.mem_write), 32'(!exp_err && w));
      check({tag, "_acc_maddr"}, bus.mem_address, a);
      check({tag, "_acc_ack"},   32'(bus.ack), 32'd0);
      tick();  // RESP cycle
      check({tag, "_ack"},       32'(bus.ack), 32'(exp_ack));
      check({tag, "_err"},       32'(bus.err), 32'(exp_err));
      check({tag, "_rdata"},     bus.rdata, exp_rd);
      check({tag, "_resp_mrd"},  32'(bus.mem_read), 32'd0);
      check({tag, "_resp_mwr"},  32'(bus.mem_write), 32'd0);
      bus.req = 2'b00;
      tick();  // back in IDLE
      check({tag, "_idle_ack"},  32'(bus.ack), 32'd0);
   endtask

   initial begin
      logic [1:0] exp_ack;
      clk        = 1'b0;
      errors     = 0;
      checks     = 0;
      pre_en     = 1'b0;
      pre_idx    = '0;
      pre_val    = 32'd0;
      bus.req    = 2'b00;
      bus.we     = 2'b00;
      bus.addr0  = 32'd0;
      bus.addr1  = 32'd0;
      bus.wdata0 = 32'd0;
      bus.wdata1 = 32'd0;
      rst_n      = 1'b1;
      #2 rst_n   = 1'b0;
      #1;
      check_idle_outputs("reset");

      preload(0, 32'hCAFE_0000);
      preload(1, 32'h1111_2222);
      preload(3, 32'hDEAD_BEEF);
      preload(4, 32'h5555_0000);
      rst_n = 1'b1;
      tick();
      check_idle_outputs("post_reset");

      // Single load of word 3.
      do_access("load3", 0, 1'b0, 32'd12, 32'd0, 1'b0, 32'hDEAD_BEEF);

      // Store then load through requester 1.
      do_access("store8", 1, 1'b1, 32'd8, 32'h0000_00A5, 1'b0, 32'd0);
      check("store8_mem", mem[2], 32'h0000_00A5);
      do_access("load8", 1, 1'b0, 32'd8, 32'd0, 1'b0, 32'h0000_00A5);

      // Illegal: misaligned load and out-of-range store.
      do_access("misalign", 0, 1'b0, 32'h0000_0802, 32'd0, 1'b1, 32'd0);
      do_access("oor", 0, 1'b1, 32'd2048, 32'hFFFF_FFFF, 1'b1, 32'd0);
      check("oor_mem0", mem[0], 32'hCAFE_0000);

      // Reset during the ACCESS cycle of a store to word 4.
      bus.addr0  = 32'd16;
      bus.wdata0 = 32'h0000_1234;
      bus.we     = 2'b01;
      bus.req    = 2'b01;
      tick();
      check("rstmid_mwr_before", 32'(bus.mem_write), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_idle_outputs("rstmid");
      tick();
      bus.req = 2'b00;
      bus.we  = 2'b00;
      rst_n   = 1'b1;
      tick();
      check("rstmid_noack", 32'(bus.ack), 32'd0);
      check("rstmid_mem4", mem[4], 32'h5555_0000);
      do_access("rstmid_read", 1, 1'b0, 32'd16, 32'd0, 1'b0, 32'h5555_0000);

      // Sustained contention from reset: acks alternate 0,1,0,1 every 3 cycles.
      rst_n = 1'b0;
      tick();
      rst_n     = 1'b1;
      bus.addr0 = 32'd0;
      bus.addr1 = 32'd4;
      bus.we    = 2'b00;
      bus.req   = 2'b11;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if ((i % 3) == 2) begin
            exp_ack = (((i / 3) % 2) == 1) ? 2'b10 : 2'b01;
         end else begin
            exp_ack = 2'b00;
         end
         check($sformatf("cont_ack_%0d", i), 32'(bus.ack), 32'(exp_ack));
         if (exp_ack == 2'b01) begin
            check($sformatf("cont_rdata_%0d", i), bus.rdata, 32'hCAFE_0000);
         end else if (exp_ack == 2'b10) begin
            check($sformatf("cont_rdata_%0d", i), bus.rdata, 32'h1111_2222);
         end
      end
      bus.req = 2'b00;
      tick();
      check("cont_end_ack", 32'(bus.ack), 32'd0);
      check("cont_end_mrd", 32'(bus.mem_read), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the single-cycle data memory. It shares one memory port between the CPU load/store path (requester 0) and a DMA/loader path (requester 1). Contention is resolved round-robin, each granted access is run as a fixed three-phase transaction, and read data is returned with a one-cycle acknowledge. It sits between the requesters and the memory's `address`/`write_data`/`mem_read`/`mem_write`/`read_data` port.

## Interface
Parameters:
- `DATA_W`, 32: data and address width.
- `MEM_WORDS`, 512: number of 32-bit words in the memory. Word index is `addr[31:2]`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req[1:0]`, in, 2: per-requester access request. It is held until `ack[i]`.
- `we[1:0]`, in, 2: per-requester write enable (1 = store, 0 = load).
- `addr0`, `addr1`, in, DATA_W: byte addresses.
- `wdata0`, `wdata1`, in, DATA_W: store data.
- `ack[1:0]`, out, 2: one-cycle completion pulse for the owning requester.
- `err`, out, 1: valid with `ack`. It is set when the access was rejected.
- `rdata`, out, DATA_W: load data, valid only while `ack` is set.
- `mem_address`, `mem_write_data`, out, DATA_W: memory address and write data.
- `mem_read`, `mem_write`, out, 1: memory strobes.
- `mem_read_data`, in, DATA_W: combinational memory read data.

## Operation
- The FSM has three states: IDLE, ACCESS, RESP.
- **IDLE**
  - Memory strobes are 0.
  - If any `req` is set at a clock edge, the arbiter picks a winner.
  - The winner's `we`, `addr` and `wdata` are latched into `owner`, `lat_we`, `lat_addr` and `lat_wdata`.
  - The FSM then moves to ACCESS.
- **ACCESS** (exactly one cycle)
  - `mem_address = lat_addr`, `mem_write_data = lat_wdata`.
  - If the address is legal: `mem_write = lat_we`, `mem_read = !lat_we`.
  - For a read, `mem_read_data` is captured into `rdata_q` at the end of the cycle.
  - A write commits at that same edge.
  - The FSM then moves to RESP.
- **RESP** (exactly one cycle)
  - `ack[owner] = 1`, `err = err_q`, `rdata = rdata_q`. For writes or errors, `rdata = 0`.
  - Strobes are 0.
  - The FSM then returns to IDLE.
- **Arbitration**
  - If only one `req` is set, that requester wins.
  - If both are set, the requester that was *not* the last granted wins.
  - `last` resets to 1, so requester 0 wins the first tie.
  - `last` updates only when the FSM enters ACCESS.
- **Illegal access**
  - Illegal means `lat_addr[1:0] != 0` or `lat_addr[31:2] >= MEM_WORDS`.
  - Both strobes stay 0 in ACCESS, so memory is untouched.
  - RESP then carries `err = 1` and `rdata = 0`.
- **Requester obligations**
  - Hold `req`, `we`, `addr` and `wdata` stable from assertion until `ack`. The arbiter latches them anyway.
  - Drop `req` in the cycle after `ack`. A `req` still set in IDLE starts a new transaction.
- **Reset**
  - With `rst_n` low, the FSM goes to IDLE and `last` goes to 1.
  - `ack`, `err`, `rdata`, the strobes, `mem_address` and `mem_write_data` all go to 0.
  - Reset during ACCESS aborts the transaction. No `ack` is issued. A write is not committed, because `rst_n` low forces `mem_write` to 0 combinationally.

## Timing
- Request sampled in IDLE at edge N. ACCESS runs in cycle N..N+1. `ack` is high in cycle N+1..N+2.
- Minimum issue-to-ack latency is 2 cycles.
- With `req` continuously high there is one transaction per 3 cycles: IDLE, ACCESS, RESP.
- Under sustained contention, grants strictly alternate 0, 1, 0, 1…
- Worst-case wait for a requester under contention is 6 cycles: the other requester's transaction plus its own.
- All outputs are registered-state decodes. None depend combinationally on `req`.

## Structure
- Package `dmem_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t`.
  - `localparam` word-index width, computed as `$clog2(MEM_WORDS)`.
- Sub-module `rr_arbiter2`: combinational 2-way round-robin pick.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `gnt_idx`, `any`.
- The top level holds the FSM, the latches and the output decode.

## Test plan
- Single load: `mem[3] = 32'hDEADBEEF`, `req0` with `addr0 = 12`, `we0 = 0`.
  - Expect `mem_read` high for exactly one cycle with `mem_address = 12`.
  - Expect `ack = 2'b01` two cycles after the request is sampled, with `rdata = 32'hDEADBEEF` and `err = 0`.
- Store then load:
  - `req1` writes `32'h0000_00A5` to `addr1 = 8`.
  - Then `req1` reads address 8.
  - Expect `rdata = 32'hA5` on the second ack.
- Contention: both `req` held high for 12 cycles after reset.
  - Expect ack order 0, 1, 0, 1, with exactly 3 cycles between acks.
- Illegal addresses: `addr0 = 32'h0000_0802` (misaligned) and `addr0 = 2048` (word 512, out of range).
  - Expect no strobe.
  - Expect `ack0` with `err = 1` and `rdata = 0`.
  - Memory contents unchanged.
- Reset mid-access:
  - Assert `rst_n = 0` during ACCESS of a write to address 16 with data `32'h1234`.
  - Expect no `ack` and `mem[4]` unchanged.
  - After release, a `req1` read of address 16 returns the old value.
